fabric_config_loader: RTL and testbench

//  Downstream of fabric_spi_controller: consumes its 32-bit bitstream word stream and writes the

---
 rtl/fabric_config_loader.sv | 174 +++++++++++++++++
 tb/tb_fabric_config_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_loader.sv
// Bitstream word consumer: finds the sync word, decodes column headers and writes frames
// into the fabric config chain. Optional checksum trailer via FABRIC_CONFIG_LOADER_CHECKSUM_EN.
module fabric_config_loader #(
  parameter int          NUM_COLUMNS        = 16,
  parameter int          MAX_FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1,
  parameter logic [31:0] END_WORD           = 32'hFFFF_FFFF,
  localparam int         SEL_W              = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
  localparam int         CNT_W              = $clog2(MAX_FRAMES_PER_COL + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [31:0]                   bitstream_data_i,
  input  logic                          bitstream_valid_i,
  input  logic                          busy_i,
  output logic [31:0]                   frame_data_o,
  output logic [SEL_W-1:0]              frame_select_o,
  output logic [MAX_FRAMES_PER_COL-1:0] frame_strobe_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    S_SEEK_SYNC = 3'd0,
    S_HEADER    = 3'd1,
    S_DATA      = 3'd2,
    S_CHECK     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [MAX_FRAMES_PER_COL-1:0] STROBE_ONE = {{(MAX_FRAMES_PER_COL-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] frame_idx;
  logic [CNT_W-1:0] frame_total;
  logic             busy_q;

  // Stream handshake: a word is taken only in the cycle bitstream_valid_i is high; there is no
  // backpressure, so every valid word is consumed at once. start_i in the same cycle drops it.
  logic       word_ok;
  logic       busy_fall;
  logic       is_sync;
  logic       is_end;
  logic [7:0] hdr_marker;
  logic [7:0] hdr_col;
  logic [7:0] hdr_cnt;
  logic       hdr_illegal;
  logic       last_frame;
  logic       in_stream;

  assign word_ok    = bitstream_valid_i && !start_i;
  assign busy_fall  = busy_q && !busy_i;
  assign is_sync    = (bitstream_data_i == SYNC_WORD);
  assign is_end     = (bitstream_data_i == END_WORD);
  assign hdr_marker = bitstream_data_i[31:24];
  assign hdr_col    = bitstream_data_i[23:16];
  assign hdr_cnt    = bitstream_data_i[15:8];
  assign hdr_illegal = (hdr_marker != 8'hA5)
                    || (32'(hdr_col) >= NUM_COLUMNS)
                    || (hdr_cnt == 8'd0)
                    || (32'(hdr_cnt) > MAX_FRAMES_PER_COL);
  assign last_frame = (frame_idx == frame_total - CNT_W'(1));
  assign in_stream  = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);

`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] xor_q;

  // Running XOR of everything between SYNC and END, compared against the trailing word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xor_q <= '0;
    end else if (word_ok) begin
      if (state_q == S_SEEK_SYNC && is_sync) begin
        xor_q <= '0;
      end else if ((state_q == S_HEADER && !is_end) || state_q == S_DATA) begin
        xor_q <= xor_q ^ bitstream_data_i;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_SEEK_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEEK_SYNC: begin
        if (word_ok && is_sync) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (word_ok) begin
          if (is_end) begin
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if (hdr_illegal) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_ok && last_frame) state_d = S_HEADER;
      end
      S_CHECK: begin
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
        if (word_ok) state_d = (bitstream_data_i == xor_q) ? S_DONE : S_ERROR;
`else
        state_d = S_ERROR;
`endif
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_SEEK_SYNC;
    endcase
    // Controller went idle mid-stream: truncated unless this very word closed the stream.
    if (busy_fall && in_stream
        && (state_d == S_HEADER || state_d == S_DATA || state_d == S_CHECK)) begin
      state_d = S_ERROR;
    end
    if (start_i) state_d = S_SEEK_SYNC;
  end

  always_comb begin
    done_o    = (state_q == S_DONE);
    error_o   = (state_q == S_ERROR);
    dbg_state = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_data_o   <= '0;
      frame_select_o <= '0;
      frame_strobe_o <= '0;
      frame_idx      <= '0;
      frame_total    <= '0;
      busy_q         <= 1'b0;
    end else begin
      frame_strobe_o <= '0;
      busy_q         <= busy_i;
      if (word_ok) begin
        case (state_q)
          S_HEADER: begin
            if (!is_end && !hdr_illegal) begin
              frame_select_o <= hdr_col[SEL_W-1:0];
              frame_idx      <= '0;
              frame_total    <= hdr_cnt[CNT_W-1:0];
            end
          end
          S_DATA: begin
            frame_data_o   <= bitstream_data_i;
            frame_strobe_o <= STROBE_ONE << frame_idx;
            frame_idx      <= frame_idx + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader: header table, hand-written corner sequences and random
// streams checked against a word-list parser model and a strobe scoreboard.
module tb_fabric_config_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] ENDW = 32'hFFFF_FFFF;
  localparam int          W    = 56;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic [31:0] frame_data;
  logic [3:0]  frame_select;
  logic [19:0] frame_strobe;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [31:0]  stream_q[$];
  logic [19:0]  ev_strobe[$];
  logic [3:0]   ev_sel[$];
  logic         m_done;
  logic         m_err;

  typedef struct {
    int          garbage;
    logic [31:0] hdr;
    int          ndata;
    bit          send_end;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  fabric_config_loader dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .bitstream_data_i (data),
    .bitstream_valid_i(valid),
    .busy_i           (busy),
    .frame_data_o     (frame_data),
    .frame_select_o   (frame_select),
    .frame_strobe_o   (frame_strobe),
    .done_o           (done),
    .error_o          (error),
    .dbg_state        (dbg_state)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected frame write, one cycle after its word.
  always @(negedge clk) begin
    if (mon_en && frame_strobe != 20'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got sel=%h strobe=%h data=%h", frame_select, frame_strobe, frame_data);
      end else begin
        logic [W-1:0] e;
        int           c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if ({frame_select, frame_strobe, frame_data} !== e || cyc != c) begin
          failures++;
          $display("FAIL strobe_event got=%h@%0d exp=%h@%0d", {frame_select, frame_strobe, frame_data}, cyc, e, c);
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [31:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    valid = 0;
  endtask

  // Parses the whole valid-word list: expected strobe per word index plus final done/error.
  task automatic model_stream();
    int          i;
    int          n;
    logic [31:0] x;
    logic [31:0] w;
    logic [7:0]  col;
    logic [7:0]  cnt;
    logic [19:0] one20;
    one20 = 20'd1;
    n = stream_q.size();
    ev_strobe.delete();
    ev_sel.delete();
    for (int k = 0; k < n; k++) begin
      ev_strobe.push_back(20'd0);
      ev_sel.push_back(4'd0);
    end
    m_done = 0;
    m_err  = 0;
    i = 0;
    while (i < n && stream_q[i] != SYNC) i++;
    if (i >= n) return;
    i++;
    x = 32'd0;
    while (1) begin
      if (i >= n) begin m_err = 1; return; end
      w = stream_q[i];
      i++;
      if (w == ENDW) begin
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
        if (i >= n) begin m_err = 1; return; end
        m_done = (stream_q[i] == x);
        m_err  = !m_done;
`else
        m_done = 1;
`endif
        return;
      end
      x = x ^ w;
      col = w[23:16];
      cnt = w[15:8];
      if (w[31:24] != 8'hA5 || col >= 8'd16 || cnt == 8'd0 || cnt > 8'd20) begin
        m_err = 1;
        return;
      end
      for (int f = 0; f < int'(cnt); f++) begin
        if (i >= n) begin m_err = 1; return; end
        ev_strobe[i] = one20 << f;
        ev_sel[i]    = col[3:0];
        x = x ^ stream_q[i];
        i++;
      end
    end
  endtask

  task automatic run_stream(input int max_gap);
    model_stream();
    start = 1;
    drive_cycle(0, 32'd0);
    start = 0;
    busy = 1;
    drive_cycle(0, 32'd0);
    for (int k = 0; k < stream_q.size(); k++) begin
      repeat ($urandom_range(max_gap, 0)) drive_cycle(0, 32'd0);
      drive_cycle(1, stream_q[k]);
      if (ev_strobe[k] != 20'd0) begin
        exp_q.push_back({ev_sel[k], ev_strobe[k], stream_q[k]});
        exp_cyc_q.push_back(cyc);
      end
    end
    busy = 0;
    repeat (3) drive_cycle(0, 32'd0);
    chk("strobes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    logic [31:0] gw[2];
    logic [31:0] xs;
    logic [31:0] w;
    logic [7:0]  col;
    logic [7:0]  cnt;
    logic [7:0]  mk;
    int          nd;

    gw[0] = 32'h1234_5678;
    gw[1] = 32'hDEAD_BEEF;
    vecs[0] = '{0, 32'hA503_0200,  2, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{2, 32'hA503_0200,  2, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{0, 32'hA510_0100,  3, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 32'hA500_1400, 20, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{0, 32'hA500_1500,  3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{0, 32'hA501_0400,  2, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{0, 32'hA50F_01FF,  1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{0, 32'hA400_0100,  1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{0, 32'hA500_0000,  1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{0, 32'hA5FF_0100,  1, 1'b0, 1'b0, 1'b1};

    rst_n = 0; start = 0; data = 0; valid = 0; busy = 0;
    #12;
    chk("rst_strobe", 64'(frame_strobe), 64'd0);
    chk("rst_data", 64'(frame_data), 64'd0);
    chk("rst_sel", 64'(frame_select), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Exact latency, hold between strobes, then start dropping a same-cycle SYNC.
    start = 1; drive_cycle(0, 32'd0); start = 0; busy = 1;
    drive_cycle(1, SYNC);
    drive_cycle(1, 32'hA503_0200);
    drive_cycle(1, 32'h1111_1111);
    chk("c1_strobe0", 64'(frame_strobe), 64'h1);
    chk("c1_data0", 64'(frame_data), 64'h1111_1111);
    chk("c1_sel", 64'(frame_select), 64'd3);
    drive_cycle(1, 32'h2222_2222);
    chk("c1_strobe1", 64'(frame_strobe), 64'h2);
    chk("c1_data1", 64'(frame_data), 64'h2222_2222);
    drive_cycle(0, 32'd0);
    chk("c1_idle_strobe", 64'(frame_strobe), 64'd0);
    chk("c1_data_hold", 64'(frame_data), 64'h2222_2222);
    drive_cycle(1, ENDW);
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
    chk("c1_not_done_before_sum", 64'(done), 64'd0);
    drive_cycle(1, 32'hA503_0200 ^ 32'h1111_1111 ^ 32'h2222_2222);
`endif
    chk("c1_done", 64'(done), 64'd1);
    chk("c1_error", 64'(error), 64'd0);
    busy = 0;
    drive_cycle(0, 32'd0);
    chk("c1_done_sticky", 64'(done), 64'd1);
    start = 1; drive_cycle(1, SYNC); start = 0;
    chk("start_clr_done", 64'(done), 64'd0);
    chk("start_keep_data", 64'(frame_data), 64'h2222_2222);
    chk("start_keep_sel", 64'(frame_select), 64'd3);
    mon_en = 1;
    busy = 1;
    drive_cycle(1, 32'hA503_0200);
    drive_cycle(1, 32'h1111_1111);
    drive_cycle(1, ENDW);
    busy = 0;
    repeat (3) drive_cycle(0, 32'd0);
    chk("dropped_sync_done", 64'(done), 64'd0);
    chk("dropped_sync_err", 64'(error), 64'd0);

    // Header table, words back-to-back.
    for (int v = 0; v < 10; v++) begin
      stream_q.delete();
      xs = 32'd0;
      for (int g = 0; g < vecs[v].garbage; g++) stream_q.push_back(gw[g]);
      stream_q.push_back(SYNC);
      stream_q.push_back(vecs[v].hdr);
      xs = xs ^ vecs[v].hdr;
      for (int i = 0; i < vecs[v].ndata; i++) begin
        w = 32'h1111_1111 * 32'(i + 1);
        stream_q.push_back(w);
        xs = xs ^ w;
      end
      if (vecs[v].send_end) begin
        stream_q.push_back(ENDW);
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
        stream_q.push_back(xs);
`endif
      end
      run_stream(0);
      chk($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      chk($sformatf("vec%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
    end

`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
    stream_q = '{SYNC, 32'hA503_0200, 32'h1111_1111, 32'h2222_2222, ENDW,
                 32'hA503_0200 ^ 32'h1111_1111 ^ 32'h2222_2222 ^ 32'h0000_0100};
    run_stream(1);
    chk("sum_flip_done", 64'(done), 64'd0);
    chk("sum_flip_error", 64'(error), 64'd1);
`endif

    // Empty slot: busy falls while still seeking sync.
    stream_q = '{32'hDEAD_BEEF};
    run_stream(0);
    chk("empty_done", 64'(done), 64'd0);
    chk("empty_error", 64'(error), 64'd0);

    // Random streams with idle gaps, bad headers, truncation and checksum corruption.
    for (int t = 0; t < 40; t++) begin
      stream_q.delete();
      xs = 32'd0;
      repeat ($urandom_range(2, 0)) begin
        w = $urandom();
        if (w == SYNC) w = 32'd0;
        stream_q.push_back(w);
      end
      if ($urandom_range(9, 0) != 0) stream_q.push_back(SYNC);
      repeat ($urandom_range(3, 1)) begin
        col = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(20, 16)) : 8'($urandom_range(15, 0));
        cnt = ($urandom_range(9, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 8'd0 : 8'd21)
                                          : 8'($urandom_range(20, 1));
        mk  = ($urandom_range(19, 0) == 0) ? 8'h5A : 8'hA5;
        w = {mk, col, cnt, 8'($urandom())};
        stream_q.push_back(w);
        xs = xs ^ w;
        nd = (cnt == 8'd0) ? 2 : int'(cnt);
        for (int i = 0; i < nd; i++) begin
          w = $urandom();
          stream_q.push_back(w);
          xs = xs ^ w;
        end
      end
      stream_q.push_back(ENDW);
`ifdef FABRIC_CONFIG_LOADER_CHECKSUM_EN
      stream_q.push_back(($urandom_range(3, 0) == 0) ? (xs ^ (32'd1 << $urandom_range(31, 0))) : xs);
`endif
      if ($urandom_range(4, 0) == 0) begin
        repeat ($urandom_range(3, 1)) if (stream_q.size() > 0) void'(stream_q.pop_back());
      end
      run_stream(2);
      chk($sformatf("rnd%0d_done", t), 64'(done), 64'(m_done));
      chk($sformatf("rnd%0d_error", t), 64'(error), 64'(m_err));
    end

    // Asynchronous reset in the middle of a data run.
    mon_en = 0;
    start = 1; drive_cycle(0, 32'd0); start = 0; busy = 1;
    drive_cycle(1, SYNC);
    drive_cycle(1, 32'hA505_0500);
    drive_cycle(1, 32'hCAFE_0001);
    drive_cycle(1, 32'hCAFE_0002);
    chk("mid_strobe", 64'(frame_strobe), 64'h2);
    chk("mid_sel", 64'(frame_select), 64'd5);
    #1 rst_n = 0;
    #1;
    chk("async_strobe", 64'(frame_strobe), 64'd0);
    chk("async_data", 64'(frame_data), 64'd0);
    chk("async_sel", 64'(frame_select), 64'd0);
    chk("async_error", 64'(error), 64'd0);
    busy = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) drive_cycle(0, 32'd0);
    chk("post_rst_error", 64'(error), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
